multicycle_sequencer: RTL

Parametrised multi-cycle control sequencer for the 16-bit processor. It steps each instruction through up to five phases: P1 fetch, P2 register read, P3 execute, P4 memory/branch and P5 write-back. In each phase it drives the datapath enables and mux selects. It owns run/stop/halt control and a retired-instruction counter. It sits between the instruction register and flag register on one side and the datapath on the other. Optionally it skips phases an instruction does not use.

---
 rtl/multicycle_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through P1..P5, drives
// datapath enables/selects, owns run/stop/halt control and a retired counter.
module multicycle_sequencer #(
    parameter int unsigned CNT_W = 32,
    parameter bit          SKIP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic [15:0]      instruction,
    input  logic             S,
    input  logic             Z,
    input  logic             C,
    input  logic             V,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             ir_e,
    output logic             pc_e,
    output logic             pc_br,
    output logic             mem_rd,
    output logic             mem_w,
    output logic             ar_e,
    output logic             br_e,
    output logic             aluc_e,
    output logic             dr_e,
    output logic             flag_e,
    output logic             out_e,
    output logic             genr_w,
    output logic             alu_a_pc,
    output logic             alu_b_imm,
    output logic [3:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             wb_ra,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_P4   = 3'd4,
        S_P5   = 3'd5,
        S_HALT = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic             stop_q, stop_d;
    logic             take_q, take_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Decode
    logic [3:0] op;
    logic       is_alu, is_ld, is_st, grp_br, is_li, is_b, is_bc, is_br;
    logic       is_cmp, is_shift, is_in, is_out, is_hlt, alu_exec, alu_wr, is_nop;
    logic       cond, br_take;
    logic       unused_bits;

    assign op          = instruction[7:4];
    assign is_alu      = (instruction[15:14] == 2'b11);
    assign is_ld       = (instruction[15:14] == 2'b00);
    assign is_st       = (instruction[15:14] == 2'b01);
    assign grp_br      = (instruction[15:14] == 2'b10);
    assign is_li       = grp_br && (instruction[13:11] == 3'b000);
    assign is_b        = grp_br && (instruction[13:11] == 3'b100);
    assign is_bc       = grp_br && (instruction[13:11] == 3'b111) && !instruction[10];
    assign is_br       = is_b || is_bc;
    assign is_cmp      = is_alu && (op == 4'd5);
    assign is_shift    = is_alu && (op[3:2] == 2'b10);
    assign is_in       = is_alu && (op == 4'd12);
    assign is_out      = is_alu && (op == 4'd13);
    assign is_hlt      = is_alu && (op == 4'd15);
    assign alu_exec    = is_alu && (op != 4'd7) && (op < 4'd12);
    assign alu_wr      = alu_exec && !is_cmp;
    assign is_nop      = (is_alu && (op == 4'd7 || op == 4'd14)) || (grp_br && !is_li && !is_br);
    assign unused_bits = ^{instruction[3:0], C};

    always_comb begin
        case (instruction[9:8])
            2'd0:    cond = Z;
            2'd1:    cond = S ^ V;
            2'd2:    cond = Z | (S ^ V);
            default: cond = !Z;
        endcase
    end
    assign br_take = is_b || (is_bc && cond);

    // Next state: each phase either advances or, at the instruction's last
    // phase, retires and loops to P1 (or IDLE when a stop is pending).
    always_comb begin
        logic last;
        logic retire;
        state_d   = state_q;
        stop_d    = stop_q;
        take_d    = take_q;
        retired_d = retired_q;
        last      = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: if (exec) state_d = S_P1;
            S_P1: state_d = S_P2;
            S_P2: begin
                if (is_hlt) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (SKIP && is_nop) last = 1'b1;
                else if (SKIP && is_li)      state_d = S_P5;
                else                         state_d = S_P3;
            end
            S_P3: begin
                if (is_br) take_d = br_take;
                if (SKIP && (is_cmp || is_out || (is_br && !br_take))) last = 1'b1;
                else if (SKIP && !(is_ld || is_st || is_br))           state_d = S_P5;
                else                                                   state_d = S_P4;
            end
            S_P4: begin
                if (SKIP && (is_st || is_br)) last = 1'b1;
                else                          state_d = S_P5;
            end
            S_P5:    last = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (running && exec) stop_d = 1'b1;
        if (last) begin
            retire  = 1'b1;
            state_d = (stop_q || exec) ? S_IDLE : S_P1;
        end
        if (retire) retired_d = retired_q + CNT_W'(1);
        if (state_d == S_IDLE) stop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            stop_q    <= 1'b0;
            take_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            take_q    <= take_d;
            retired_q <= retired_d;
        end
    end

    assign phase   = state_q;
    assign running = (state_q >= S_P1) && (state_q <= S_P5);
    assign halted  = (state_q == S_HALT);
    assign retired = retired_q;

    always_comb begin
        ir_e = 1'b0; pc_e = 1'b0; pc_br = 1'b0; mem_rd = 1'b0; mem_w = 1'b0;
        ar_e = 1'b0; br_e = 1'b0; aluc_e = 1'b0; dr_e = 1'b0; flag_e = 1'b0;
        out_e = 1'b0; genr_w = 1'b0; alu_a_pc = 1'b0; alu_b_imm = 1'b0;
        alu_op = '0; wb_sel = '0; wb_ra = 1'b0;
        case (state_q)
            S_P1: begin
                mem_rd = 1'b1;
                ir_e   = 1'b1;
                pc_e   = 1'b1;
            end
            S_P2: begin
                ar_e = 1'b1;
                br_e = 1'b1;
            end
            S_P3: begin
                if (alu_exec) begin
                    aluc_e    = 1'b1;
                    dr_e      = !is_cmp;
                    flag_e    = 1'b1;
                    alu_b_imm = is_shift;
                    alu_op    = op;
                end else if (is_ld || is_st) begin
                    aluc_e    = 1'b1;
                    dr_e      = 1'b1;
                    alu_b_imm = 1'b1;
                end else if (is_br) begin
                    aluc_e    = 1'b1;
                    dr_e      = 1'b1;
                    alu_a_pc  = 1'b1;
                    alu_b_imm = 1'b1;
                end else if (is_out) begin
                    out_e = 1'b1;
                end
            end
            S_P4: begin
                mem_rd = is_ld;
                mem_w  = is_st;
                pc_e   = is_br && take_q;
                pc_br  = is_br && take_q;
            end
            S_P5: begin
                if (alu_wr) begin
                    genr_w = 1'b1;
                end else if (is_in) begin
                    genr_w = 1'b1;
                    wb_sel = 2'd3;
                end else if (is_ld) begin
                    genr_w = 1'b1;
                    wb_sel = 2'd1;
                    wb_ra  = 1'b1;
                end else if (is_li) begin
                    genr_w = 1'b1;
                    wb_sel = 2'd2;
                end
            end
            default: ;
        endcase
    end

endmodule
